// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM states for the PS/2 receive port.
package ps2_pkg;
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_REL = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises the PS/2 pins, debounces the clock line and emits a one-cycle
// strobe on each accepted falling edge of the filtered clock.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2clk_ext,
  input  logic ps2data_ext,
  output logic data_sync,
  output logic bit_strobe
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d   = filt_q;
    cnt_d    = '0;
    if (clk_sync_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    strobe_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
    end else begin
      clk_meta_q  <= ps2clk_ext;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2data_ext;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      strobe_q    <= strobe_d;
    end
  end

  assign data_sync  = data_sync_q;
  assign bit_strobe = strobe_q;
endmodule

// File: rtl/ps2_port.sv
// PS/2 receive port: frames 11-bit PS/2 words into bytes and reports them,
// folding E0/F0 prefixes into extended/released flags in keyboard mode.
module ps2_port
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_rcv,
  input  logic       kb_or_mouse,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       kb_interrupt,
  output logic [7:0] scancode,
  output logic       released,
  output logic       extended
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic data_sync, bit_strobe;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2clk_ext (ps2clk_ext),
    .ps2data_ext(ps2data_ext),
    .data_sync  (data_sync),
    .bit_strobe (bit_strobe)
  );

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_flag_q, ext_flag_d;
  logic          rel_flag_q, rel_flag_d;
  logic          kb_interrupt_q, kb_interrupt_d;
  logic [7:0]    scancode_q, scancode_d;
  logic          released_q, released_d;
  logic          extended_q, extended_d;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    parity_d       = parity_q;
    ext_flag_d     = ext_flag_q;
    rel_flag_d     = rel_flag_q;
    kb_interrupt_d = 1'b0;
    scancode_d     = scancode_q;
    released_d     = released_q;
    extended_d     = extended_q;
    tmo_d          = (bit_strobe || state_q == IDLE) ? '0 : tmo_q + TW'(1);

    if (!enable_rcv) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bit_strobe && !data_sync) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          if (bit_strobe) begin
            shift_d   = {data_sync, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = PARITY;
          end
        end
        PARITY: begin
          if (bit_strobe) begin
            parity_d = data_sync;
            state_d  = STOP;
          end
        end
        STOP: begin
          if (bit_strobe) begin
            state_d = IDLE;
            if (data_sync && (^{shift_q, parity_q})) begin
              if (kb_or_mouse) begin
                scancode_d     = shift_q;
                released_d     = 1'b0;
                extended_d     = 1'b0;
                kb_interrupt_d = 1'b1;
                ext_flag_d     = 1'b0;
                rel_flag_d     = 1'b0;
              end else if (shift_q == PREFIX_EXT) begin
                ext_flag_d = 1'b1;
              end else if (shift_q == PREFIX_REL) begin
                rel_flag_d = 1'b1;
              end else begin
                scancode_d     = shift_q;
                released_d     = rel_flag_q;
                extended_d     = ext_flag_q;
                kb_interrupt_d = 1'b1;
                ext_flag_d     = 1'b0;
                rel_flag_d     = 1'b0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // A stalled sender abandons the frame but leaves pending prefixes intact.
      if (state_q != IDLE && !bit_strobe && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      parity_q       <= 1'b0;
      tmo_q          <= '0;
      ext_flag_q     <= 1'b0;
      rel_flag_q     <= 1'b0;
      kb_interrupt_q <= 1'b0;
      scancode_q     <= 8'h00;
      released_q     <= 1'b0;
      extended_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_q       <= parity_d;
      tmo_q          <= tmo_d;
      ext_flag_q     <= ext_flag_d;
      rel_flag_q     <= rel_flag_d;
      kb_interrupt_q <= kb_interrupt_d;
      scancode_q     <= scancode_d;
      released_q     <= released_d;
      extended_q     <= extended_d;
    end
  end

  assign kb_interrupt = kb_interrupt_q;
  assign scancode     = scancode_q;
  assign released     = released_q;
  assign extended     = extended_q;
endmodule

// File: tb/tb_ps2_port.sv
// Bench for ps2_port: directed scenarios plus a random byte stream scored
// against a prefix-folding reference model.
module tb_ps2_port;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_rcv = 1'b1;
  logic       kb_or_mouse = 1'b0;
  logic       ps2clk_ext = 1'b1;
  logic       ps2data_ext = 1'b1;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic       released;
  logic       extended;

  localparam int TMO = 2000;

  ps2_port #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_rcv  (enable_rcv),
    .kb_or_mouse (kb_or_mouse),
    .ps2clk_ext  (ps2clk_ext),
    .ps2data_ext (ps2data_ext),
    .kb_interrupt(kb_interrupt),
    .scancode    (scancode),
    .released    (released),
    .extended    (extended)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Observed reports: {scancode, released, extended}
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  logic       prev_int = 1'b0;
  int         long_pulse = 0;
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;

  always @(negedge clk) begin
    if (kb_interrupt) begin
      obs_q.push_back({scancode, released, extended});
      if (prev_int) long_pulse++;
    end
    prev_int = kb_interrupt;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_range(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2data_ext = f[i];
      repeat (15) @(posedge clk);
      ps2clk_ext = 1'b0;
      repeat (30) @(posedge clk);
      ps2clk_ext = 1'b1;
      repeat (15) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_range(mk_frame(b, bad_par), 0, 10);
    ps2data_ext = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  // Reference behaviour of one received frame, applied at the byte level.
  task automatic model_byte(input logic [7:0] b, input logic good, input logic mouse);
    if (good) begin
      if (mouse) begin
        exp_q.push_back({b, 2'b00});
        m_ext = 1'b0;
        m_rel = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_rel = 1'b1;
      end else begin
        exp_q.push_back({b, m_rel, m_ext});
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({kb_interrupt, scancode, released, extended} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got int=%b sc=%h rel=%b ext=%b, want all 0",
               kb_interrupt, scancode, released, extended);
    end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    obs_q.delete();
  endtask

  task automatic test_kb_basic;
    obs_q.delete();
    send_frame(8'h16, 1'b0);
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL basic_count: got %0d reports, want 1", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== {8'h16, 2'b00}) begin
        bad++; $display("FAIL basic_report: got %h, want %h", obs_q[0], {8'h16, 2'b00});
      end
    end
    total++;
    if (scancode !== 8'h16 || kb_interrupt !== 1'b0) begin
      bad++; $display("FAIL basic_hold: got sc=%h int=%b, want sc=16 int=0", scancode, kb_interrupt);
    end
  endtask

  task automatic test_break;
    obs_q.delete();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1E, 1'b0);
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL break_count: got %0d reports, want 1", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== {8'h1E, 2'b10}) begin
        bad++; $display("FAIL break_report: got %h, want %h", obs_q[0], {8'h1E, 2'b10});
      end
    end
  endtask

  task automatic test_ext_break;
    obs_q.delete();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'h75, 1'b0);
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL ext_count: got %0d reports, want 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== {8'h75, 2'b11}) begin
        bad++; $display("FAIL ext_break_report: got %h, want %h", obs_q[0], {8'h75, 2'b11});
      end
      total++;
      if (obs_q[1] !== {8'h75, 2'b00}) begin
        bad++; $display("FAIL ext_flags_cleared: got %h, want %h", obs_q[1], {8'h75, 2'b00});
      end
    end
  endtask

  task automatic test_parity;
    obs_q.delete();
    send_frame(8'h26, 1'b1);
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL bad_parity_dropped: got %0d reports, want 0", obs_q.size());
    end
    send_frame(8'h26, 1'b0);
    total++;
    if (obs_q.size() != 1 || obs_q[obs_q.size()-1] !== {8'h26, 2'b00}) begin
      bad++; $display("FAIL good_after_bad: got %0d reports last=%h, want 1 report %h",
                      obs_q.size(), obs_q.size() ? obs_q[obs_q.size()-1] : 10'h0, {8'h26, 2'b00});
    end
  endtask

  task automatic test_timeout_mouse;
    obs_q.delete();
    send_range(mk_frame(8'h5A, 1'b0), 0, 4);
    ps2data_ext = 1'b1;
    repeat (TMO + 500) @(posedge clk);
    send_frame(8'h25, 1'b0);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {8'h25, 2'b00}) begin
      bad++; $display("FAIL timeout_recover: got %0d reports first=%h, want 1 report %h",
                      obs_q.size(), obs_q.size() ? obs_q[0] : 10'h0, {8'h25, 2'b00});
    end
    obs_q.delete();
    kb_or_mouse = 1'b1;
    send_frame(8'hF0, 1'b0);
    send_frame(8'hE0, 1'b0);
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL mouse_count: got %0d reports, want 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== {8'hF0, 2'b00} || obs_q[1] !== {8'hE0, 2'b00}) begin
        bad++; $display("FAIL mouse_raw: got %h %h, want %h %h", obs_q[0], obs_q[1],
                        {8'hF0, 2'b00}, {8'hE0, 2'b00});
      end
    end
    kb_or_mouse = 1'b0;
  endtask

  task automatic test_enable_glitch;
    obs_q.delete();
    send_range(mk_frame(8'h3D, 1'b0), 0, 3);
    enable_rcv = 1'b0;
    send_range(mk_frame(8'h3D, 1'b0), 4, 10);
    ps2data_ext = 1'b1;
    repeat (40) @(posedge clk);
    enable_rcv = 1'b1;
    repeat (20) @(posedge clk);
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL disabled_no_pulse: got %0d reports, want 0", obs_q.size());
    end
    // Short low pulse with data low would look like a start bit if not filtered.
    ps2data_ext = 1'b0;
    repeat (5) @(posedge clk);
    ps2clk_ext = 1'b0;
    repeat (2) @(posedge clk);
    ps2clk_ext = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h3D, 1'b0);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {8'h3D, 2'b00}) begin
      bad++; $display("FAIL glitch_ignored: got %0d reports first=%h, want 1 report %h",
                      obs_q.size(), obs_q.size() ? obs_q[0] : 10'h0, {8'h3D, 2'b00});
    end
  endtask

  task automatic test_rst_mid;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h4B, 1'b0);
    send_range(mk_frame(8'h33, 1'b0), 0, 5);
    rst = 1'b1;
    #1;
    total++;
    if ({kb_interrupt, scancode, released, extended} !== 11'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got int=%b sc=%h rel=%b ext=%b, want all 0",
                      kb_interrupt, scancode, released, extended);
    end
    ps2data_ext = 1'b1;
    repeat (10) @(posedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    obs_q.delete();
    send_frame(8'h1C, 1'b0);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {8'h1C, 2'b00}) begin
      bad++; $display("FAIL after_rst_frame: got %0d reports first=%h, want 1 report %h",
                      obs_q.size(), obs_q.size() ? obs_q[0] : 10'h0, {8'h1C, 2'b00});
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic       bp;
    logic       ms;
    obs_q.delete();
    exp_q.delete();
    m_ext = 1'b0;
    m_rel = 1'b0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 7) == 0);
      ms = ($urandom_range(0, 3) == 0);
      kb_or_mouse = ms;
      send_frame(b, bp);
      model_byte(b, !bp, ms);
    end
    kb_or_mouse = 1'b0;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_count: got %0d reports, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL random_report[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (long_pulse != 0) begin
      bad++; $display("FAIL pulse_width: got %0d multi-cycle pulses, want 0", long_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_kb_basic();
    test_break();
    test_ext_break();
    test_parity();
    test_timeout_mouse();
    test_enable_glitch();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
